// File: rtl/divider_8_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// divider_8_arbiter_ctrl
//
// Two requesters (A and B) share one 8-bit restoring divider. An idle/compute/
// done FSM grants the divider to one requester at a time. Ties go round-robin,
// and A wins first after reset. The FSM latches the winner's operands, runs one
// quotient bit per cycle, then holds the result until the grantee acks.
//
// Ports
//   ClkPort              in   sole clock, rising edge
//   Reset                in   asynchronous active-low reset
//   ReqA, XinA, YinA     in   requester A request, dividend, divisor
//   ReqB, XinB, YinB     in   requester B request, dividend, divisor
//   Ack                  in   grantee has consumed the result (only used in QD)
//   GntA, GntB           out  current owner of the divider (one-hot or idle)
//   Quotient, Remainder  out  result of the last completed division
//   Done                 out  result valid (same as Qd)
//   Qi, Qc, Qd           out  one-hot state indication
//   DivZero              out  divide-by-zero flag, meaningful while Done=1
//
// Build option
//   DIVIDER_8_DIVZERO_TRAP_EN : when defined, a zero divisor skips the compute
//   phase. The FSM goes straight to QD with Quotient=FF, Remainder=dividend and
//   DivZero=1. When not defined, a zero divisor runs the normal compute phase.
//   That also gives FF/dividend, and DivZero is tied low.
//
// state | meaning
// ------+----------------------------------------------------------
// QI    | idle, arbitrating between ReqA and ReqB
// QC    | compute, one restoring-division step per cycle
// QD    | done, result presented, waiting for Ack from the grantee
// -----------------------------------------------------------------------------
module divider_8_arbiter_ctrl (
  input  logic       ClkPort,
  input  logic       Reset,
  input  logic       ReqA,
  input  logic [7:0] XinA,
  input  logic [7:0] YinA,
  input  logic       ReqB,
  input  logic [7:0] XinB,
  input  logic [7:0] YinB,
  input  logic       Ack,
  output logic       GntA,
  output logic       GntB,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       Done,
  output logic       Qi,
  output logic       Qc,
  output logic       Qd,
  output logic       DivZero
);

  typedef enum logic [1:0] {
    QI = 2'd0,
    QC = 2'd1,
    QD = 2'd2
  } state_t;

  // Compute steps run while cnt_q counts 0..7. The result is committed on the
  // edge where cnt_q==8. QD is therefore entered 9 edges after the grant edge.
  localparam logic [3:0] CNT_COMMIT = 4'd8;

  state_t     state_q, state_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       last_a_q, last_a_d;   // 1: A was served last, 0: B was
  logic [7:0] work_q, work_d;       // dividend bits shift out, quotient bits shift in
  logic [7:0] rem_q, rem_d;         // partial remainder, always < divisor after a step
  logic [7:0] dvsr_q, dvsr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] remo_q, remo_d;

  logic       pick_a;
  logic [7:0] sel_x;
  logic [7:0] sel_y;
  logic [8:0] trial;
  logic       trial_ge;
  logic [7:0] trial_diff;

`ifdef DIVIDER_8_DIVZERO_TRAP_EN
  logic       div_zero_q, div_zero_d;
`endif

  // A wins when it asks alone, or when both ask and B was served last.
  assign pick_a = ReqA & (~ReqB | ~last_a_q);
  assign sel_x  = pick_a ? XinA : XinB;
  assign sel_y  = pick_a ? YinA : YinB;

  // Restoring step: bring down the next dividend bit. Subtract the divisor if
  // the 9-bit trial value is at least the zero-extended divisor. When the
  // subtraction happens, the difference is below 256, so 8 bits hold it.
  assign trial      = {rem_q, work_q[7]};
  assign trial_ge   = (trial >= {1'b0, dvsr_q});
  assign trial_diff = trial[7:0] - dvsr_q;

  always_comb begin
    state_d  = state_q;
    gnt_a_d  = gnt_a_q;
    gnt_b_d  = gnt_b_q;
    last_a_d = last_a_q;
    work_d   = work_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    remo_d   = remo_q;
`ifdef DIVIDER_8_DIVZERO_TRAP_EN
    div_zero_d = div_zero_q;
`endif

    case (state_q)
      QI: begin
        // Ack is deliberately not looked at here. A held Ack must not delay
        // the next grant.
        if (ReqA | ReqB) begin
          gnt_a_d = pick_a;
          gnt_b_d = ~pick_a;
          work_d  = sel_x;
          dvsr_d  = sel_y;
          rem_d   = 8'd0;
          cnt_d   = 4'd0;
          state_d = QC;
`ifdef DIVIDER_8_DIVZERO_TRAP_EN
          if (sel_y == 8'd0) begin
            state_d    = QD;
            quot_d     = 8'hFF;
            remo_d     = sel_x;
            div_zero_d = 1'b1;
          end
`endif
        end
      end

      QC: begin
        if (cnt_q == CNT_COMMIT) begin
          state_d = QD;
          quot_d  = work_q;
          remo_d  = rem_q;
`ifdef DIVIDER_8_DIVZERO_TRAP_EN
          div_zero_d = 1'b0;
`endif
        end else begin
          rem_d  = trial_ge ? trial_diff : trial[7:0];
          work_d = {work_q[6:0], trial_ge};
          cnt_d  = cnt_q + 4'd1;
        end
      end

      QD: begin
        if (Ack) begin
          state_d  = QI;
          gnt_a_d  = 1'b0;
          gnt_b_d  = 1'b0;
          last_a_d = gnt_a_q;
        end
      end

      default: begin
        state_d = QI;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      state_q  <= QI;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      last_a_q <= 1'b0;    // B counts as last served, so A wins the first tie
      work_q   <= 8'd0;
      rem_q    <= 8'd0;
      dvsr_q   <= 8'd0;
      cnt_q    <= 4'd0;
      quot_q   <= 8'd0;
      remo_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      last_a_q <= last_a_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      remo_q   <= remo_d;
    end
  end

`ifdef DIVIDER_8_DIVZERO_TRAP_EN
  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= div_zero_d;
    end
  end

  assign DivZero = div_zero_q;
`else
  assign DivZero = 1'b0;
`endif

  assign GntA      = gnt_a_q;
  assign GntB      = gnt_b_q;
  assign Quotient  = quot_q;
  assign Remainder = remo_q;
  assign Qi        = (state_q == QI);
  assign Qc        = (state_q == QC);
  assign Qd        = (state_q == QD);
  assign Done      = Qd;

endmodule

// File: tb/tb_divider_8_arbiter_ctrl.sv
module tb_divider_8_arbiter_ctrl;

  logic       ClkPort;
  logic       Reset;
  logic       ReqA;
  logic [7:0] XinA;
  logic [7:0] YinA;
  logic       ReqB;
  logic [7:0] XinB;
  logic [7:0] YinB;
  logic       Ack;
  logic       GntA;
  logic       GntB;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Done;
  logic       Qi;
  logic       Qc;
  logic       Qd;
  logic       DivZero;

  int n_checks;
  int n_errors;

`ifdef DIVIDER_8_DIVZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  divider_8_arbiter_ctrl dut (
    .ClkPort   (ClkPort),
    .Reset     (Reset),
    .ReqA      (ReqA),
    .XinA      (XinA),
    .YinA      (YinA),
    .ReqB      (ReqB),
    .XinB      (XinB),
    .YinB      (YinB),
    .Ack       (Ack),
    .GntA      (GntA),
    .GntB      (GntB),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Done      (Done),
    .Qi        (Qi),
    .Qc        (Qc),
    .Qd        (Qd),
    .DivZero   (DivZero)
  );

  initial begin
    ClkPort = 1'b0;
    forever #5 ClkPort = ~ClkPort;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClkPort);
    #1;
  endtask

  // Counts the edges until Done rises. The count is bounded, so a stuck FSM
  // shows up as an edge count that does not match.
  task automatic wait_done(output int edges);
    edges = 0;
    while (Done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  int edges;

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b0;
    ReqA = 1'b0; XinA = 8'd0; YinA = 8'd0;
    ReqB = 1'b0; XinB = 8'd0; YinB = 8'd0;
    Ack  = 1'b0;

    // ---- reset state ----
    do_reset();
    check_val("rst_state", {Qi, Qc, Qd, Done}, 4'b1000);
    check_val("rst_gnt",   {GntA, GntB}, 2'b00);
    check_val("rst_qr",    {Quotient, Remainder}, 16'h0000);
    check_val("rst_dz",    DivZero, 1'b0);

    // ---- single requester A: 100 / 7 = 14 r 2 ----
    ReqA = 1'b1; XinA = 8'd100; YinA = 8'd7;
    tick();
    check_val("a_grant", {GntA, GntB, Qc}, 3'b101);
    ReqA = 1'b0;
    wait_done(edges);
    check_val("a_latency", edges, 9);
    check_val("a_quot", Quotient, 8'd14);
    check_val("a_rem",  Remainder, 8'd2);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check_val("a_ack", {Qi, GntA}, 2'b10);
    check_val("a_hold_qi", {Quotient, Remainder}, {8'd14, 8'd2});

    // ---- tie after reset: A first, then B, then A again ----
    do_reset();
    ReqA = 1'b1; XinA = 8'd255; YinA = 8'd1;
    ReqB = 1'b1; XinB = 8'd5;   YinB = 8'd9;
    tick();
    check_val("tie1_gnt", {GntA, GntB}, 2'b10);
    wait_done(edges);
    check_val("tie1_res", {Quotient, Remainder}, {8'd255, 8'd0});
    Ack = 1'b1;
    tick();
    check_val("tie1_ack", {Qi, GntA, GntB}, 3'b100);
    tick();   // Ack still held in QI; it must not block the grant
    check_val("tie2_gnt", {Qc, GntA, GntB}, 3'b101);
    Ack = 1'b0;
    wait_done(edges);
    check_val("tie2_lat", edges, 9);
    check_val("tie2_res", {Quotient, Remainder}, {8'd0, 8'd5});
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    tick();
    check_val("tie3_gnt", {GntA, GntB}, 2'b10);
    ReqA = 1'b0; ReqB = 1'b0;
    wait_done(edges);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;

    // ---- divide by zero: 0x3C / 0 ----
    do_reset();
    ReqA = 1'b1; XinA = 8'h3C; YinA = 8'd0;
    tick();
    ReqA = 1'b0;
    if (TRAP) begin
      check_val("dz_trap_done", {Qd, GntA}, 2'b11);
    end else begin
      check_val("dz_qc", {Qc, GntA}, 2'b11);
      wait_done(edges);
      check_val("dz_latency", edges, 9);
    end
    check_val("dz_res",  {Quotient, Remainder}, {8'hFF, 8'h3C});
    check_val("dz_flag", DivZero, TRAP);

    // ---- reset in the 4th QC cycle, pending B granted after release ----
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    ReqA = 1'b1; XinA = 8'd100; YinA = 8'd7;
    tick();
    check_val("mr_grant", {Qc, GntA}, 2'b11);
    ReqA = 1'b0;
    ReqB = 1'b1; XinB = 8'd50; YinB = 8'd6;
    tick(); tick(); tick();
    #1;
    Reset = 1'b0;
    #1;
    check_val("mr_state", {Qi, Qc, Qd, Done}, 4'b1000);
    check_val("mr_gnt",   {GntA, GntB}, 2'b00);
    check_val("mr_qr",    {Quotient, Remainder, 7'd0, DivZero}, 24'h0);
    #1;
    Reset = 1'b1;
    tick();
    check_val("mr_b_gnt", {Qc, GntA, GntB}, 3'b101);
    ReqB = 1'b0;
    wait_done(edges);
    check_val("mr_b_res", {Quotient, Remainder}, {8'd8, 8'd2});
    Ack = 1'b1;
    tick();

    // ---- Ack held, request dropped and operand changed during QC ----
    ReqA = 1'b1; XinA = 8'd200; YinA = 8'd13;
    tick();
    check_val("hq_grant", {Qc, GntA}, 2'b11);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        ReqA = 1'b0;
        XinA = 8'd1;
      end
      tick();
      check_val($sformatf("hq_qc%0d", i), {Qc, GntA}, 2'b11);
    end
    tick();
    check_val("hq_done", Done, 1'b1);
    check_val("hq_res", {Quotient, Remainder}, {8'd15, 8'd5});
    tick();
    check_val("hq_ack", {Qi, GntA}, 2'b10);
    check_val("hq_hold", {Quotient, Remainder}, {8'd15, 8'd5});
    Ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
